ntt_twiddle_seq_ctrl: RTL

Configuration and run sequencer for the pipelined NTT core (top_top_module).
- On a go command, it copies the base twiddle table from an external ROM into each stage's twiddle RAM, decimated per stage.
- It then streams one frame of radix samples into the core with start held high, and waits for done.
- This replaces the manual write_en/addr/data and start driving currently done in benches.

---
 rtl/ntt_ctrl_pkg.sv | 22 ++
 rtl/ntt_twiddle_loader.sv | 97 +++++++++
 rtl/ntt_twiddle_seq_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ntt_ctrl_pkg.sv
// ntt_ctrl_pkg: shared state type and twiddle index helpers for the NTT run sequencer.
package ntt_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOAD_FLUSH,
    FEED,
    WAIT_DONE
  } ctrl_state_t;

  // Number of twiddle entries held by stage s of a radix-point NTT.
  function automatic int stage_len(input int radix, input int s);
    return radix >> (s + 1);
  endfunction

  // Base ROM index feeding entry i of stage s (the table is decimated by 2^s).
  function automatic int rom_index(input int s, input int i);
    return i << s;
  endfunction

endpackage

// File: rtl/ntt_twiddle_loader.sv
// ntt_twiddle_loader: walks every stage/index pair, reads the base twiddle ROM
// and steers each returned word into the matching stage's twiddle RAM lane.
module ntt_twiddle_loader #(
  parameter int W          = 32,
  parameter int RADIX      = 16,
  parameter int NUM_STAGES = $clog2(RADIX),
  parameter int ADDR_WIDTH = $clog2(RADIX / 2)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  output logic                             done_o,
  output logic [ADDR_WIDTH-1:0]            rom_addr_o,
  input  logic [W-1:0]                     rom_data_i,
  output logic [NUM_STAGES-1:0]            write_en_o,
  output logic [NUM_STAGES*ADDR_WIDTH-1:0] write_addr_o,
  output logic [NUM_STAGES*W-1:0]          write_data_o
);
  import ntt_ctrl_pkg::*;

  localparam int SW = $clog2(NUM_STAGES) + 1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

  logic                             active_q;
  logic [SW-1:0]                    stage_q, stage_d;
  logic [ADDR_WIDTH-1:0]            idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]            romAddr_q;
  logic [NUM_STAGES-1:0]            wen_q;
  logic [NUM_STAGES*ADDR_WIDTH-1:0] waddr_q;
  logic                             stageEnd;
  logic                             lastAddr;

  // Next stage/index pair; terminal values are tested before any increment.
  always_comb begin
    stageEnd = (int'(idx_q) == stage_len(RADIX, int'(stage_q)) - 1);
    lastAddr = active_q && stageEnd && (stage_q == LAST_STAGE);
    stage_d  = stage_q;
    idx_d    = idx_q + ADDR_WIDTH'(1);
    if (stageEnd) begin
      idx_d   = '0;
      stage_d = stage_q + SW'(1);
    end
  end

  // Address generator plus one-cycle-delayed write enable/address lanes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q  <= 1'b0;
      stage_q   <= '0;
      idx_q     <= '0;
      romAddr_q <= '0;
      wen_q     <= '0;
      waddr_q   <= '0;
    end else begin
      wen_q   <= '0;
      waddr_q <= '0;
      if (start_i) begin
        active_q  <= 1'b1;
        stage_q   <= '0;
        idx_q     <= '0;
        romAddr_q <= '0;
      end else if (active_q) begin
        for (int s = 0; s < NUM_STAGES; s++) begin
          if (int'(stage_q) == s) begin
            wen_q[s]                              <= 1'b1;
            waddr_q[s*ADDR_WIDTH +: ADDR_WIDTH]   <= idx_q;
          end
        end
        if (lastAddr) begin
          active_q  <= 1'b0;
          stage_q   <= '0;
          idx_q     <= '0;
          romAddr_q <= '0;
        end else begin
          stage_q   <= stage_d;
          idx_q     <= idx_d;
          romAddr_q <= ADDR_WIDTH'(rom_index(int'(stage_d), int'(idx_d)));
        end
      end
    end
  end

  // Write data comes straight from the ROM's output register, gated onto the
  // single active lane so idle lanes read zero.
  always_comb begin
    write_data_o = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (wen_q[s]) write_data_o[s*W +: W] = rom_data_i;
    end
  end

  assign done_o       = lastAddr;
  assign rom_addr_o   = romAddr_q;
  assign write_en_o   = wen_q;
  assign write_addr_o = waddr_q;

endmodule

// File: rtl/ntt_twiddle_seq_ctrl.sv
// ntt_twiddle_seq_ctrl: on go, optionally reloads the per-stage twiddle RAMs,
// then streams one frame of samples into the NTT core and waits for done.
module ntt_twiddle_seq_ctrl #(
  parameter int W          = 32,
  parameter int RADIX      = 16,
  parameter int NUM_STAGES = $clog2(RADIX),
  parameter int ADDR_WIDTH = $clog2(RADIX / 2)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             go_i,
  input  logic                             go_reload_i,
  output logic                             busy_o,
  output logic                             frame_done_o,
  output logic                             tables_valid_o,
  output logic [ADDR_WIDTH-1:0]            rom_addr_o,
  input  logic [W-1:0]                     rom_data_i,
  input  logic                             in_valid_i,
  input  logic [W-1:0]                     in_data_i,
  output logic                             in_ready_o,
  output logic                             underrun_o,
  output logic [NUM_STAGES-1:0]            write_en_array_o,
  output logic [NUM_STAGES*ADDR_WIDTH-1:0] write_addr_array_o,
  output logic [NUM_STAGES*W-1:0]          write_data_array_o,
  output logic                             ntt_start_o,
  output logic [W-1:0]                     ntt_data_o,
  input  logic                             ntt_done_i
);
  import ntt_ctrl_pkg::*;

  localparam int BW = $clog2(RADIX) + 1;
  localparam logic [BW-1:0] BEATS = BW'(RADIX);

  ctrl_state_t   state_q;
  logic          busy_q;
  logic          frameDone_q;
  logic          tablesValid_q;
  logic          inReady_q;
  logic          underrun_q;
  logic          nttStart_q;
  logic [W-1:0]  nttData_q;
  logic [BW-1:0] beatCnt_q;
  logic          loadStart;
  logic          loadDone;

  // A reload is forced whenever the RAMs do not hold a complete table.
  always_comb begin
    loadStart = (state_q == IDLE) && go_i && (go_reload_i || !tablesValid_q);
  end

  ntt_twiddle_loader #(
    .W(W), .RADIX(RADIX), .NUM_STAGES(NUM_STAGES), .ADDR_WIDTH(ADDR_WIDTH)
  ) u_loader (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (loadStart),
    .done_o       (loadDone),
    .rom_addr_o   (rom_addr_o),
    .rom_data_i   (rom_data_i),
    .write_en_o   (write_en_array_o),
    .write_addr_o (write_addr_array_o),
    .write_data_o (write_data_array_o)
  );

  // Sequencer: go handling, table-valid tracking, frame feed and done wait.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      frameDone_q   <= 1'b0;
      tablesValid_q <= 1'b0;
      inReady_q     <= 1'b0;
      underrun_q    <= 1'b0;
      nttStart_q    <= 1'b0;
      nttData_q     <= '0;
      beatCnt_q     <= '0;
    end else begin
      frameDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go_i) begin
            underrun_q <= 1'b0;
            busy_q     <= 1'b1;
            if (loadStart) begin
              tablesValid_q <= 1'b0;
              state_q       <= LOAD;
            end else begin
              inReady_q <= 1'b1;
              beatCnt_q <= '0;
              state_q   <= FEED;
            end
          end
        end
        LOAD: begin
          if (loadDone) state_q <= LOAD_FLUSH;
        end
        LOAD_FLUSH: begin
          tablesValid_q <= 1'b1;
          inReady_q     <= 1'b1;
          beatCnt_q     <= '0;
          state_q       <= FEED;
        end
        FEED: begin
          if (beatCnt_q == BEATS) begin
            nttData_q <= '0;
            state_q   <= WAIT_DONE;
          end else if (in_valid_i) begin
            nttData_q  <= in_data_i;
            nttStart_q <= 1'b1;
            beatCnt_q  <= beatCnt_q + BW'(1);
            if (beatCnt_q == BEATS - BW'(1)) inReady_q <= 1'b0;
          end else if (beatCnt_q != '0) begin
            underrun_q <= 1'b1;
            nttData_q  <= '0;
          end
        end
        WAIT_DONE: begin
          if (ntt_done_i) begin
            nttStart_q  <= 1'b0;
            frameDone_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign frame_done_o   = frameDone_q;
  assign tables_valid_o = tablesValid_q;
  assign in_ready_o     = inReady_q;
  assign underrun_o     = underrun_q;
  assign ntt_start_o    = nttStart_q;
  assign ntt_data_o     = nttData_q;

endmodule
